fetch_sequencer: RTL and testbench

- Request side of the dual-issue instruction fetch path: generates the aligned instruction-pair address pair (pc, pc+4) presented to the instruction reader each cycle.
- Captures the two returned instruction words and buffers them in a small FIFO.
- Hands them to decode over a valid/ready handshake, with branch redirect and end-of-program drain/halt.
- Sits between the core's PC/redirect logic and the decode stage; it owns the architectural fetch PC.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_pair_fifo.sv | 65 ++++++
 rtl/fetch_sequencer.sv | 113 +++++++++++
 tb/tb_fetch_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the dual-issue fetch path: sequencer state and pair-entry layout.
// No logic of its own.
// Backpressure: not applicable.
package fetch_pkg;

    localparam int PC_SIZE_DEF    = 32;
    localparam int INSTR_SIZE_DEF = 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    // Reference layout of one buffered pair at the default widths; the FIFO
    // stores the same field order as a flat vector so other widths work too.
    typedef struct packed {
        logic [PC_SIZE_DEF-1:0]    pc;
        logic                      slot0_valid;
        logic [INSTR_SIZE_DEF-1:0] instr0;
        logic [INSTR_SIZE_DEF-1:0] instr1;
    } fetch_entry_t;

    function automatic int entry_width(input int pc_w, input int instr_w);
        return pc_w + 1 + 2 * instr_w;
    endfunction

endpackage

// File: rtl/fetch_pair_fifo.sv
// Small flushable FIFO holding fetched instruction pairs; head is read straight from storage.
// Latency: a push is visible at head_dat the next cycle.
// Backpressure: push is ignored when full without a same-cycle pop; pop is ignored when empty.
module fetch_pair_fifo #(
    parameter int WIDTH = 97,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign head_dat = mem[rd_ptr];

    // Storage, pointers and occupancy; flush drops every entry at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the fetch PC, requests aligned instruction pairs, buffers them and hands them to decode.
// Latency: pair fetched in cycle N is presented on pair_* in cycle N+1; redirect target valid in N+2.
// Backpressure: fetch stalls (PC held) when the pair buffer is full and decode does not pop.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                  PC_SIZE    = PC_SIZE_DEF,
    parameter int                  INSTR_SIZE = INSTR_SIZE_DEF,
    parameter logic [PC_SIZE-1:0]  RESET_PC   = '0,
    parameter int                  FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    output logic [PC_SIZE-1:0]    pc0_o,
    output logic [PC_SIZE-1:0]    pc1_o,
    input  logic [INSTR_SIZE-1:0] instr0_i,
    input  logic [INSTR_SIZE-1:0] instr1_i,
    input  logic                  done_i,
    input  logic                  redirect_valid_i,
    input  logic [PC_SIZE-1:0]    redirect_pc_i,
    output logic                  pair_valid_o,
    input  logic                  pair_ready_i,
    output logic [PC_SIZE-1:0]    pair_pc_o,
    output logic                  pair_slot0_valid_o,
    output logic [INSTR_SIZE-1:0] pair_instr0_o,
    output logic [INSTR_SIZE-1:0] pair_instr1_o,
    output logic                  halted_o
);

    localparam int EW = entry_width(PC_SIZE, INSTR_SIZE);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t          state;
    fetch_state_t          state_nxt;
    logic [PC_SIZE-1:0]    fpc;
    logic                  slot0_live;
    logic [PC_SIZE-1:0]    redirect_aligned;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  pop;
    logic                  push;
    logic                  drain_empty;
    logic [EW-1:0]         push_dat;
    logic [EW-1:0]         head_dat;
    logic                  unused_bits;

    // Word offset bits of the redirect target carry no meaning for pair fetch.
    assign unused_bits      = ^redirect_pc_i[1:0];
    assign redirect_aligned = {redirect_pc_i[PC_SIZE-1:3], 3'b000};

    assign pc0_o        = fpc;
    assign pc1_o        = fpc + PC_SIZE'(4);
    assign halted_o     = (state == ST_HALT);
    assign pair_valid_o = ~empty & (state != ST_HALT);
    assign pop          = pair_valid_o & pair_ready_i;
    assign push         = (state == ST_RUN) & ~done_i & ~redirect_valid_i & (~full | pop);
    // Buffer will be empty after this cycle (no pushes happen while draining).
    assign drain_empty  = empty | ((count == CW'(1)) & pop);
    assign push_dat     = {fpc, slot0_live, instr0_i, instr1_i};

    assign {pair_pc_o, pair_slot0_valid_o, pair_instr0_o, pair_instr1_o} = head_dat;

    fetch_pair_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .flush    (redirect_valid_i),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    // Next-state: redirect restarts fetching from any state; end of program drains then halts.
    always_comb begin
        state_nxt = state;
        if (redirect_valid_i) begin
            state_nxt = ST_RUN;
        end else begin
            case (state)
                ST_RUN:   if (done_i) state_nxt = ST_DRAIN;
                ST_DRAIN: if (drain_empty) state_nxt = ST_HALT;
                ST_HALT:  state_nxt = ST_HALT;
                default:  state_nxt = ST_RUN;
            endcase
        end
    end

    // Fetch PC, state and the pending slot-0-dead marker left by a mid-pair redirect.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= ST_RUN;
            fpc        <= RESET_PC;
            slot0_live <= 1'b1;
        end else begin
            state <= state_nxt;
            if (redirect_valid_i) begin
                fpc        <= redirect_aligned;
                slot0_live <= ~redirect_pc_i[2];
            end else if (push) begin
                fpc        <= fpc + PC_SIZE'(8);
                slot0_live <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by randomized traffic.
// Outputs are compared every cycle against a queue-based model of the pair stream.
// Runs with an 8-bit PC so address wrap is reachable.
module tb_fetch_sequencer;

    localparam int PCW   = 8;
    localparam int IW    = 32;
    localparam int DEPTH = 2;

    logic           clk_i = 1'b0;
    logic           rst_n_i = 1'b0;
    logic [PCW-1:0] pc0_o;
    logic [PCW-1:0] pc1_o;
    logic [IW-1:0]  instr0_i;
    logic [IW-1:0]  instr1_i;
    logic           done_i;
    logic           redirect_valid_i = 1'b0;
    logic [PCW-1:0] redirect_pc_i = '0;
    logic           pair_valid_o;
    logic           pair_ready_i = 1'b0;
    logic [PCW-1:0] pair_pc_o;
    logic           pair_slot0_valid_o;
    logic [IW-1:0]  pair_instr0_o;
    logic [IW-1:0]  pair_instr1_o;
    logic           halted_o;

    logic           done_en = 1'b0;
    logic [PCW-1:0] end_pc = 8'hFF;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    // Instruction memory: every word holds its own address.
    function automatic logic [IW-1:0] rd_word(input logic [PCW-1:0] a);
        return {24'h0, a};
    endfunction

    assign instr0_i = rd_word(pc0_o);
    assign instr1_i = rd_word(pc1_o);
    assign done_i   = done_en && (pc0_o >= end_pc);

    fetch_sequencer #(
        .PC_SIZE    (PCW),
        .INSTR_SIZE (IW),
        .RESET_PC   (8'h00),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i              (clk_i),
        .rst_n_i            (rst_n_i),
        .pc0_o              (pc0_o),
        .pc1_o              (pc1_o),
        .instr0_i           (instr0_i),
        .instr1_i           (instr1_i),
        .done_i             (done_i),
        .redirect_valid_i   (redirect_valid_i),
        .redirect_pc_i      (redirect_pc_i),
        .pair_valid_o       (pair_valid_o),
        .pair_ready_i       (pair_ready_i),
        .pair_pc_o          (pair_pc_o),
        .pair_slot0_valid_o (pair_slot0_valid_o),
        .pair_instr0_o      (pair_instr0_o),
        .pair_instr1_o      (pair_instr1_o),
        .halted_o           (halted_o)
    );

    // Reference model: a queue of delivered-to-be pairs plus fetch address and mode.
    typedef struct {
        logic [PCW-1:0] pc;
        logic           s0;
        logic [IW-1:0]  w0;
        logic [IW-1:0]  w1;
    } ent_t;

    ent_t           q[$];
    logic [PCW-1:0] m_pc = '0;
    logic           m_s0 = 1'b1;
    int             m_mode = 0;      // 0 fetching, 1 draining, 2 halted
    logic           m_pop;
    ent_t           m_e;

    // Advance the model by one clock using the inputs the bench drove this cycle.
    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q.delete();
            m_pc   = '0;
            m_s0   = 1'b1;
            m_mode = 0;
        end else begin
            m_pop = (q.size() > 0) && (m_mode != 2) && pair_ready_i;
            if (redirect_valid_i) begin
                q.delete();
                m_pc   = redirect_pc_i & 8'hF8;
                m_s0   = !redirect_pc_i[2];
                m_mode = 0;
            end else begin
                if (m_pop) void'(q.pop_front());
                if (m_mode == 0) begin
                    if (done_en && (m_pc >= end_pc)) begin
                        m_mode = 1;
                    end else if (q.size() < DEPTH) begin
                        m_e.pc = m_pc;
                        m_e.s0 = m_s0;
                        m_e.w0 = rd_word(m_pc);
                        m_e.w1 = rd_word(m_pc + 8'd4);
                        q.push_back(m_e);
                        m_pc = m_pc + 8'd8;
                        m_s0 = 1'b1;
                    end
                end else if (m_mode == 1 && q.size() == 0) begin
                    m_mode = 2;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic           v_exp;
        logic [PCW-1:0] p1;
        v_exp = (q.size() > 0) && (m_mode != 2);
        p1    = m_pc + 8'd4;
        check("model_pc0", 32'(pc0_o), 32'(m_pc));
        check("model_pc1", 32'(pc1_o), 32'(p1));
        check("model_valid", 32'(pair_valid_o), 32'(v_exp));
        check("model_halted", 32'(halted_o), 32'(m_mode == 2));
        if (v_exp && pair_valid_o) begin
            check("model_pair_pc", 32'(pair_pc_o), 32'(q[0].pc));
            check("model_slot0", 32'(pair_slot0_valid_o), 32'(q[0].s0));
            check("model_instr0", pair_instr0_o, q[0].w0);
            check("model_instr1", pair_instr1_o, q[0].w1);
        end
    endtask

    // One clock: outputs are sampled 1 time unit after the rising edge.
    task automatic cycle();
        @(posedge clk_i);
        #1;
        if (rst_n_i) compare_model();
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_pc0", 32'(pc0_o), 32'h0);
        check("rst_pc1", 32'(pc1_o), 32'h4);
        check("rst_valid", 32'(pair_valid_o), 32'h0);
        check("rst_halted", 32'(halted_o), 32'h0);
        check("rst_pair_pc", 32'(pair_pc_o), 32'h0);
        check("rst_instr0", pair_instr0_o, 32'h0);
        check("rst_instr1", pair_instr1_o, 32'h0);
        rst_n_i = 1'b1;

        // Streaming with decode always ready
        pair_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("stream_valid", 32'(pair_valid_o), 32'h1);
            check("stream_pc", 32'(pair_pc_o), 32'(8 * k));
            check("stream_instr0", pair_instr0_o, 32'(8 * k));
            check("stream_instr1", pair_instr1_o, 32'(8 * k + 4));
        end

        // Reset asserted mid-stream takes effect without a clock
        rst_n_i = 1'b0;
        #1;
        check("midrst_pc0", 32'(pc0_o), 32'h0);
        check("midrst_pc1", 32'(pc1_o), 32'h4);
        check("midrst_valid", 32'(pair_valid_o), 32'h0);
        check("midrst_halted", 32'(halted_o), 32'h0);
        pair_ready_i = 1'b0;
        cycle();
        rst_n_i = 1'b1;

        // Backpressure: buffer saturates, fetch PC holds
        repeat (5) cycle();
        check("bp_pc0_hold", 32'(pc0_o), 32'h10);
        check("bp_head", 32'(pair_pc_o), 32'h0);
        check("bp_valid", 32'(pair_valid_o), 32'h1);
        pair_ready_i = 1'b1;
        for (int k = 1; k < 4; k++) begin
            cycle();
            check("bp_release_pc", 32'(pair_pc_o), 32'(8 * k));
        end

        // Redirect to a slot-1 target while full, with a simultaneous pop
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 8'h44;
        cycle();
        redirect_valid_i = 1'b0;
        check("redir_valid_low", 32'(pair_valid_o), 32'h0);
        check("redir_pc0", 32'(pc0_o), 32'h40);
        cycle();
        check("redir_tgt_valid", 32'(pair_valid_o), 32'h1);
        check("redir_tgt_pc", 32'(pair_pc_o), 32'h40);
        check("redir_tgt_slot0", 32'(pair_slot0_valid_o), 32'h0);
        check("redir_tgt_instr1", pair_instr1_o, 32'h44);
        cycle();
        check("redir_next_pc", 32'(pair_pc_o), 32'h48);
        check("redir_next_slot0", 32'(pair_slot0_valid_o), 32'h1);

        // End of program at 0x20: drain then halt
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 8'h00;
        done_en          = 1'b1;
        end_pc           = 8'h20;
        cycle();
        redirect_valid_i = 1'b0;
        repeat (4) cycle();
        check("eop_pc0", 32'(pc0_o), 32'h20);
        check("eop_head", 32'(pair_pc_o), 32'h18);
        pair_ready_i = 1'b0;
        repeat (3) cycle();
        check("drain_pc0_hold", 32'(pc0_o), 32'h20);
        check("drain_valid", 32'(pair_valid_o), 32'h1);
        check("drain_not_halted", 32'(halted_o), 32'h0);
        pair_ready_i = 1'b1;
        cycle();
        check("halt_rise", 32'(halted_o), 32'h1);
        check("halt_valid", 32'(pair_valid_o), 32'h0);
        check("halt_pc0", 32'(pc0_o), 32'h20);
        cycle();
        check("halt_stays", 32'(halted_o), 32'h1);

        // Restart from halt, then wrap the 8-bit fetch address
        done_en          = 1'b0;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 8'h00;
        cycle();
        redirect_valid_i = 1'b0;
        check("restart_halted", 32'(halted_o), 32'h0);
        check("restart_pc0", 32'(pc0_o), 32'h0);
        cycle();
        check("restart_valid", 32'(pair_valid_o), 32'h1);
        check("restart_head", 32'(pair_pc_o), 32'h0);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 8'hF9;
        cycle();
        redirect_valid_i = 1'b0;
        check("wrap_pc0_f8", 32'(pc0_o), 32'hF8);
        cycle();
        check("wrap_pc0_00", 32'(pc0_o), 32'h00);
        check("wrap_head", 32'(pair_pc_o), 32'hF8);
        check("wrap_slot0", 32'(pair_slot0_valid_o), 32'h1);
        check("wrap_instr1", pair_instr1_o, 32'hFC);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            pair_ready_i     = ($urandom_range(0, 9) < 7);
            redirect_valid_i = ($urandom_range(0, 19) == 0);
            redirect_pc_i    = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 49) == 0) begin
                done_en = ~done_en;
                end_pc  = 8'($urandom_range(0, 255));
            end
            if ((i % 700) == 350) begin
                rst_n_i = 1'b0;
                #1;
                check("rand_rst_pc0", 32'(pc0_o), 32'h0);
                check("rand_rst_valid", 32'(pair_valid_o), 32'h0);
                check("rand_rst_halted", 32'(halted_o), 32'h0);
                cycle();
                rst_n_i = 1'b1;
            end else begin
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
